// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction uses nines complement of b with an inverted initial carry (ten's complement).
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   z,
  output logic                  cout,
  output logic                  invalid
);

  localparam int unsigned W = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          sub_q, sub_d;
  logic          c_q, c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  z_q, z_d;
  logic          cout_q, cout_d;
  logic          invalid_q, invalid_d;

  logic [3:0]    bd_c;
  logic [4:0]    sum_c;
  logic [3:0]    digit_c;
  logic          carry_c;
  logic          bad_c;

  // Single digit stage with +6 correction; operates on raw 4-bit values.
  always_comb begin
    bd_c    = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    sum_c   = 5'(a_q[3:0]) + 5'(bd_c) + 5'(c_q);
    carry_c = (sum_c > 5'd9);
    digit_c = carry_c ? 4'(sum_c + 5'd6) : sum_c[3:0];
  end

  // Any digit above 9 in the operands being accepted.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sub_d     = sub_q;
    c_d       = c_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    z_d       = z_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          a_d       = a;
          b_d       = b;
          sub_d     = op_sub;
          c_d       = op_sub ? ~cin : cin;
          invalid_d = bad_c;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = (res_q >> 4) | (W'(digit_c) << (W - 4));
        c_d   = carry_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          z_d     = (res_q >> 4) | (W'(digit_c) << (W - 4));
          cout_d  = carry_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      z_q       <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      z_q       <= z_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign z       = z_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4) with hand-computed results.
module tb_bcd_serial_addsub;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] z;
  logic        cout;
  logic        invalid;

  int checks;
  int failures;

  bcd_serial_addsub #(.DIGITS(4), .CW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_sub  (op_sub),
    .cin     (cin),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .z       (z),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done; returns busy cycles seen. Ends sampling inside the done cycle.
  task automatic wait_done(input string tag, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start(input logic [15:0] av, input logic [15:0] bv,
                             input logic sub, input logic ci);
    @(posedge clk); #1;
    a = av; b = bv; op_sub = sub; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sub, input logic ci, input logic [15:0] ez,
                        input logic ec, input logic einv);
    int nb;
    pulse_start(av, bv, sub, ci);
    wait_done(tag, nb);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd4);
    check({tag, "_z"}, 32'(z), 32'(ez));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_inv"}, 32'(invalid), 32'(einv));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  nb;
    bit  seen;
    checks   = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_inv", 32'(invalid), 32'd0);

    // Additions
    run_op("add_0999", 16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("add_ovf",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin",  16'h4567, 16'h5433, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Subtractions
    run_op("sub_1000", 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0);
    run_op("sub_brw",  16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
    run_op("sub_bin",  16'h0500, 16'h0200, 1'b1, 1'b1, 16'h0299, 1'b1, 1'b0);

    // Handshake: start while busy ignored
    pulse_start(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 16'h9999; b = 16'h9999; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("hs_first", nb);
    check("hs_first_busy_left", 32'(nb), 32'd2);
    check("hs_first_z", 32'(z), 32'h2345);
    check("hs_first_cout", 32'(cout), 32'd0);
    // Start accepted in the done cycle, no idle gap
    a = 16'h0005; b = 16'h0005; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("hs_b2b_busy", 32'(busy), 32'd1);
    check("hs_b2b_done", 32'(done), 32'd0);
    wait_done("hs_b2b", nb);
    check("hs_b2b_busy_left", 32'(nb), 32'd3);
    check("hs_b2b_z", 32'(z), 32'h0010);

    // Invalid digit flagged from the start; result follows raw arithmetic
    pulse_start(16'h00A3, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("inv_early", 32'(invalid), 32'd1);
    wait_done("inv", nb);
    check("inv_busy_left", 32'(nb), 32'd3);
    check("inv_hold", 32'(invalid), 32'd1);
    check("inv_z", 32'(z), 32'h0104);
    run_op("inv_clear", 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0);

    // Reset mid-operation
    pulse_start(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_z", 32'(z), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_inv", 32'(invalid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);
    run_op("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised multi-digit packed-BCD adder/subtractor.
- Processes one decimal digit per clock, least significant digit first, using a single digit-correction stage (+6 when the 5-bit digit sum exceeds 9).
- Successor to the single-digit combinational BCD sum: it adds N-digit width, subtraction (ten's complement), a start/busy/done handshake, and invalid-digit detection.
- Sits between operand registers and display/accumulator logic.

Parameters:
- DIGITS, 4, number of BCD digits per operand (must be >= 1).
- CW, 3, width of the internal digit counter; must satisfy 2^CW >= DIGITS.

Ports:
- clk, input, 1, single system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request a new operation; sampled only when not busy.
- op_sub, input, 1, 0 = add (a+b+cin); 1 = subtract (a-b-cin).
- cin, input, 1, carry-in for add; borrow-in for subtract.
- a, input, 4*DIGITS, operand A, packed BCD; digit i is a[4i+3:4i].
- b, input, 4*DIGITS, operand B, packed BCD.
- busy, output, 1, high while digits are being processed.
- done, output, 1, one-cycle pulse when the result is valid.
- z, output, 4*DIGITS, result in packed BCD.
- cout, output, 1, add: decimal carry out. Subtract: 1 = no borrow, 0 = borrow (result is the ten's complement).
- invalid, output, 1, high if any captured digit of a or b was greater than 9.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: busy=0, done=0, z=0, cout=0, invalid=0. State returns to IDLE and the counter is cleared. Reset overrides start and aborts any operation in progress; the partial result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: done=1 for one cycle, busy=0.
- IDLE or FIN with start=1:
  - Capture a, b and op_sub into internal shift registers.
  - Initial digit carry: cin when op_sub=0; ~cin when op_sub=1.
  - Compute invalid from the captured operands; it is held until the next accepted start.
  - Clear the counter and go to RUN.
- FIN with start=0 goes to IDLE. FIN accepts start exactly like IDLE, so back-to-back operations run with no idle gap.
- RUN, each cycle, for the current digit d:
  - bd = b_d when adding; bd = 9 - b_d (nines complement, 4-bit) when subtracting.
  - s = a_d + bd + c, computed at 5 bits.
  - If s > 9: digit = (s + 6) mod 16 and c = 1. Otherwise digit = s[3:0] and c = 0.
  - Shift the digit into the result shift register and increment the counter.
  - After digit DIGITS-1: go to FIN, load z from the result shift register, and set cout = final c.
- Latency: start accepted at edge k → busy=1 during cycles k+1 … k+DIGITS → done=1 during cycle k+DIGITS+1, with z and cout updated at that same edge.
- z, cout and invalid hold their values until the next completion, reset, or (for invalid) the next accepted start.
- start while busy=1 is ignored; operand changes while busy have no effect.
- Invalid digits (>9): no error recovery. The arithmetic above still runs on the raw 4-bit values, and the result is unspecified but deterministic.
- Wrap-around: add overflow gives z = sum mod 10^DIGITS with cout=1. Subtract with b > a gives z = 10^DIGITS + a - b - cin with cout=0.
- DIGITS=1 degenerates to a single-digit operation with a 1-cycle busy phase.

Test Plan (DIGITS=4):
1. Add, a=0999, b=0001, cin=0, start pulse → busy for 4 cycles, then done=1 one cycle with z=1000, cout=0, invalid=0.
2. Add overflow, a=9999, b=0001, cin=0 → z=0000, cout=1. Then a=4567, b=5433, cin=1 → z=0001, cout=1.
3. Subtract, op_sub=1, a=1000, b=0001, cin=0 → z=0999, cout=1. Then a=0001, b=0002, cin=0 → z=9999, cout=0 (borrow).
4. Handshake: pulse start with a=1234, b=1111, then pulse start again 2 cycles later with different operands → second start ignored, z=2345. Then assert start in the done cycle with a=0005, b=0005 → accepted, busy rises next cycle, z=0010 four cycles later.
5. Invalid input, a=00A3, b=0001 → invalid=1 at the start of the operation, done still pulses after 4 busy cycles. A following valid operation clears invalid.
6. Reset: start an operation, assert reset in cycle 2 of busy → next cycle busy=0, done=0, z=0000, cout=0, invalid=0, and no done pulse follows. A new start then completes normally.
